// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ readout buffer: write FSM encodings and status bit map.
package daq_pkg;

   typedef enum logic [3:0] {
      W_IDLE   = 4'd0,
      W_FILL   = 4'd1,
      W_DROP   = 4'd2,
      W_COMMIT = 4'd3
   } wstate_e;

   localparam int unsigned ST_TRUNC_BIT = 7;
   localparam int unsigned ST_DROP_BIT  = 6;
   localparam int unsigned ST_UNDER_BIT = 5;
   localparam int unsigned LEN_W        = 11;
   localparam int unsigned CNT_W        = 6;

endpackage

// File: rtl/daq_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// The read register is clearable so the consumer sees zeros after reset.
module daq_sdp_ram #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 512,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (clr_i) rdata_o <= '0;
      else       rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/daq_readout_buffer.sv
// Multi-slot readout store feeding the DMA manager: one packet per slot, ring of NBUF slots.
// Optional per-packet drop counter enabled by defining DAQ_BUF_DROP_CNT_EN.
module daq_readout_buffer
   import daq_pkg::*;
#(
   parameter int unsigned NBUF_LOG2      = 4,
   parameter int unsigned BUF_WORDS_LOG2 = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic [5:0]  pick_buf_id,
   input  logic [10:0] r_ptr,
   output logic [63:0] data_from_buffer,
   output logic [10:0] buf_len,
   output logic [5:0]  r_buf_id,
   output logic [5:0]  nreadouts_available,
   input  logic        done_with_buffer,
   output logic [7:0]  status
`ifdef DAQ_BUF_DROP_CNT_EN
   ,
   output logic [15:0] drop_count
`endif
);

   localparam int unsigned NBUF      = 1 << NBUF_LOG2;
   localparam int unsigned BUF_WORDS = 1 << BUF_WORDS_LOG2;
   localparam int unsigned CW        = BUF_WORDS_LOG2 + 1;
   localparam int unsigned DA        = NBUF_LOG2 + BUF_WORDS_LOG2 - 1;
   localparam int unsigned DDEPTH    = 1 << DA;

   wstate_e              state_q, state_d;
   logic [NBUF_LOG2-1:0] w_id_q, w_id_d, r_id_q, r_id_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [CW-1:0]        wcnt_q, wcnt_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [31:0]          even_q, even_d;
   logic                 trunc_q, trunc_d, drop_q, drop_d, under_q, under_d;

   logic                 clr_c, commit_c, release_c, start_c, full_c, store_c, drop_inc_c;
   logic [NBUF_LOG2-1:0] wid_c;
   logic [CW-1:0]        idx_c;
   logic [CNT_W-1:0]     occ_c;
   logic                 dwe_c;
   logic [DA-1:0]        dwaddr_c, draddr_c;
   logic [63:0]          dwdata_c;

   assign clr_c     = reset | ~enable;
   assign commit_c  = (state_q == W_COMMIT);
   assign release_c = done_with_buffer && (count_q != '0);
   assign start_c   = in_valid && ((state_q == W_IDLE) || commit_c);
   // During a commit cycle a new packet already targets the next slot
   assign wid_c     = commit_c ? NBUF_LOG2'(w_id_q + 1'b1) : w_id_q;
   assign idx_c     = start_c ? '0 : wcnt_q;
   assign occ_c     = count_q + CNT_W'(commit_c);
   assign full_c    = (occ_c == CNT_W'(NBUF));

   always_ff @(posedge clk) begin
      if (clr_c) begin
         state_q <= W_IDLE;
         w_id_q  <= '0;
         r_id_q  <= '0;
         count_q <= '0;
         wcnt_q  <= '0;
         len_q   <= '0;
         even_q  <= '0;
         trunc_q <= 1'b0;
         drop_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         w_id_q  <= w_id_d;
         r_id_q  <= r_id_d;
         count_q <= count_d;
         wcnt_q  <= wcnt_d;
         len_q   <= len_d;
         even_q  <= even_d;
         trunc_q <= trunc_d;
         drop_q  <= drop_d;
         under_q <= under_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      w_id_d     = w_id_q;
      r_id_d     = r_id_q;
      count_d    = count_q;
      wcnt_d     = wcnt_q;
      len_d      = len_q;
      even_d     = even_q;
      trunc_d    = trunc_q;
      drop_d     = drop_q;
      under_d    = under_q;
      store_c    = 1'b0;
      drop_inc_c = 1'b0;
      dwe_c      = 1'b0;
      dwaddr_c   = '0;
      dwdata_c   = '0;

      if (commit_c) begin
         w_id_d  = wid_c;
         state_d = W_IDLE;
      end

      case (state_q)
         W_IDLE, W_COMMIT: begin
            if (in_valid) begin
               if (full_c) begin
                  drop_d = 1'b1;
                  if (in_last) drop_inc_c = 1'b1;
                  else         state_d    = W_DROP;
               end else begin
                  store_c = 1'b1;
                  state_d = in_last ? W_COMMIT : W_FILL;
               end
            end
         end
         W_FILL: begin
            if (in_valid) begin
               store_c = 1'b1;
               if (in_last) state_d = W_COMMIT;
            end
         end
         W_DROP: begin
            if (in_valid && in_last) begin
               drop_inc_c = 1'b1;
               state_d    = W_IDLE;
            end
         end
         default: state_d = W_IDLE;
      endcase

      // Even words wait in a holding register; odd words (or a trailing even word) hit the RAM
      if (store_c) begin
         if (idx_c == CW'(BUF_WORDS)) begin
            trunc_d = 1'b1;
         end else begin
            wcnt_d   = idx_c + CW'(1);
            dwaddr_c = DA'({wid_c, idx_c[BUF_WORDS_LOG2-1:0]} >> 1);
            if (!idx_c[0]) begin
               even_d = in_data;
               if (in_last) begin
                  dwe_c    = 1'b1;
                  dwdata_c = {32'h0, in_data};
               end
            end else begin
               dwe_c    = 1'b1;
               dwdata_c = {in_data, even_q};
            end
         end
         if (in_last) begin
            len_d = (idx_c == CW'(BUF_WORDS)) ? LEN_W'(idx_c) : LEN_W'(idx_c) + LEN_W'(1);
         end
      end

      if (release_c) r_id_d = NBUF_LOG2'(r_id_q + 1'b1);
      if (done_with_buffer && (count_q == '0)) under_d = 1'b1;

      case ({commit_c, release_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   assign draddr_c = DA'({pick_buf_id[NBUF_LOG2-1:0], r_ptr[BUF_WORDS_LOG2-1:0]} >> 1);

   daq_sdp_ram #(
      .WIDTH (64),
      .DEPTH (DDEPTH)
   ) u_data_ram (
      .clk     (clk),
      .clr_i   (clr_c),
      .we_i    (dwe_c),
      .waddr_i (dwaddr_c),
      .wdata_i (dwdata_c),
      .raddr_i (draddr_c),
      .rdata_o (data_from_buffer)
   );

   daq_sdp_ram #(
      .WIDTH (LEN_W),
      .DEPTH (NBUF)
   ) u_len_ram (
      .clk     (clk),
      .clr_i   (clr_c),
      .we_i    (commit_c),
      .waddr_i (w_id_q),
      .wdata_i (len_q),
      .raddr_i (pick_buf_id[NBUF_LOG2-1:0]),
      .rdata_o (buf_len)
   );

   assign r_buf_id            = CNT_W'(r_id_q);
   assign nreadouts_available = count_q;

   always_comb begin
      status               = '0;
      status[ST_TRUNC_BIT] = trunc_q;
      status[ST_DROP_BIT]  = drop_q;
      status[ST_UNDER_BIT] = under_q;
      status[3:0]          = state_q;
   end

`ifdef DAQ_BUF_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_inc_c && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (clr_c) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`else
   logic unused_drop_c;
   assign unused_drop_c = drop_inc_c;
`endif

   logic unused_addr_c;
   assign unused_addr_c = ^{pick_buf_id[5:NBUF_LOG2], r_ptr[10:BUF_WORDS_LOG2]};

endmodule
